cache_mem_arbiter: RTL and testbench

Two-requester arbiter that shares the single unified RAM port between the instruction cache and the data cache of the pipelined core. It sits between the caches and RAM, serializing fetch and load/store traffic. Data requests normally have priority, and a starvation counter guarantees forward progress for instruction fetches. Each grant holds the RAM port until the RAM reports ACCESS for that requester.

---
 rtl/cache_mem_arbiter.sv | 134 +++++++++++++
 tb/tb_cache_mem_arbiter.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/cache_mem_arbiter.sv
// cache_mem_arbiter
//   Shares the single unified RAM port between the instruction cache and the
//   data cache. Data traffic normally wins. A saturating starvation counter
//   forces an instruction grant after STARVE_MAX back-to-back data
//   completions while a fetch is pending. A grant owns the port until RAM
//   reports ACCESS for that requester, or until the requester withdraws.
//
// Ports
//   CLK, nRST                 clock (rising edge), async active-low reset
//   iREN, iaddr               instruction read request / word address
//   iload, iwait              instruction read data / stall
//   dREN, dWEN, daddr, dstore data read / write request, address, write data
//   dload, dwait              data read data / stall
//   ramREN, ramWEN            RAM strobes (combinational from grant)
//   ramaddr, ramstore         RAM address / write data
//   ramload, ramstate         RAM read data / status (FREE, BUSY, ACCESS, ERROR)
//   grant                     current FSM state for debug (IDLE, GNT_I, GNT_D)
module cache_mem_arbiter #(
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        iREN,
  input  logic [31:0] iaddr,
  output logic [31:0] iload,
  output logic        iwait,
  input  logic        dREN,
  input  logic        dWEN,
  input  logic [31:0] daddr,
  input  logic [31:0] dstore,
  output logic [31:0] dload,
  output logic        dwait,
  output logic        ramREN,
  output logic        ramWEN,
  output logic [31:0] ramaddr,
  output logic [31:0] ramstore,
  input  logic [31:0] ramload,
  input  logic [1:0]  ramstate,
  output logic [1:0]  grant
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GNT_I = 2'd1,
    GNT_D = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    RAM_FREE   = 2'd0,
    RAM_BUSY   = 2'd1,
    RAM_ACCESS = 2'd2,
    RAM_ERROR  = 2'd3
  } ramstate_t;

  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  state_t     state;
  logic [3:0] starve;

  logic dreq;
  logic access;
  logic i_done;
  logic d_done;
  logic force_i;

  assign dreq    = dREN | dWEN;
  assign access  = (ramstate == RAM_ACCESS);
  assign i_done  = (state == GNT_I) & iREN & access;
  assign d_done  = (state == GNT_D) & dreq & access;
  assign force_i = iREN & (starve == STARVE_LIM);

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state  <= IDLE;
      starve <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (dreq && !force_i)
            state <= GNT_D;
          else if (iREN)
            state <= GNT_I;
        end
        GNT_D: begin
          // Withdrawal and completion both release the port.
          if (!dreq || access)
            state <= IDLE;
        end
        GNT_I: begin
          if (!iREN || access)
            state <= IDLE;
        end
        default: state <= IDLE;
      endcase

      // A cycle without a pending fetch clears, so a data completion on the
      // cycle before iREN rises never counts toward starvation.
      if (!iREN || i_done)
        starve <= '0;
      else if (d_done && (starve != STARVE_LIM))
        starve <= starve + 4'd1;
    end
  end

  always_comb begin
    ramREN   = 1'b0;
    ramWEN   = 1'b0;
    ramaddr  = '0;
    ramstore = '0;
    case (state)
      GNT_I: begin
        ramREN  = iREN;
        ramaddr = iaddr;
      end
      GNT_D: begin
        ramaddr = daddr;
        if (dWEN) begin
          ramWEN   = 1'b1;
          ramstore = dstore;
        end else begin
          ramREN = dREN;
        end
      end
      default: ;
    endcase
  end

  assign iwait = iREN & ~((state == GNT_I) & access);
  assign dwait = dreq & ~((state == GNT_D) & access);
  assign iload = ramload;
  assign dload = ramload;
  assign grant = state;

endmodule

// File: tb/tb_cache_mem_arbiter.sv
module tb_cache_mem_arbiter;

  localparam int SMAX = 4;

  logic        CLK = 1'b0;
  logic        nRST;
  logic        iREN;
  logic [31:0] iaddr;
  logic [31:0] iload;
  logic        iwait;
  logic        dREN;
  logic        dWEN;
  logic [31:0] daddr;
  logic [31:0] dstore;
  logic [31:0] dload;
  logic        dwait;
  logic        ramREN;
  logic        ramWEN;
  logic [31:0] ramaddr;
  logic [31:0] ramstore;
  logic [31:0] ramload;
  logic [1:0]  ramstate;
  logic [1:0]  grant;

  cache_mem_arbiter #(.STARVE_MAX(SMAX)) dut (
    .CLK(CLK), .nRST(nRST),
    .iREN(iREN), .iaddr(iaddr), .iload(iload), .iwait(iwait),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
    .dload(dload), .dwait(dwait),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ramstate(ramstate), .grant(grant)
  );

  always #5 CLK = ~CLK;

  int errs   = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // Reference model: who owns the port (0 nobody, 1 fetch, 2 data) and how
  // many data completions the pending fetch has watched go by.
  int owner = 0;
  int wait_cnt = 0;

  task automatic model_reset();
    owner = 0;
    wait_cnt = 0;
  endtask

  task automatic check_model();
    bit dr;
    bit acc;
    logic [31:0] e_addr, e_store;
    bit e_ren, e_wen;
    dr  = dREN || dWEN;
    acc = (ramstate == 2'd2);
    e_ren = 0; e_wen = 0; e_addr = 0; e_store = 0;
    if (owner == 1) begin
      e_ren = iREN; e_addr = iaddr;
    end else if (owner == 2) begin
      e_addr = daddr;
      if (dWEN) begin e_wen = 1; e_store = dstore; end
      else e_ren = dREN;
    end
    chk("m_iwait", {31'd0, iwait}, {31'd0, iREN && !(owner == 1 && acc)});
    chk("m_dwait", {31'd0, dwait}, {31'd0, dr && !(owner == 2 && acc)});
    chk("m_ramREN", {31'd0, ramREN}, {31'd0, e_ren});
    chk("m_ramWEN", {31'd0, ramWEN}, {31'd0, e_wen});
    chk("m_ramaddr", ramaddr, e_addr);
    chk("m_ramstore", ramstore, e_store);
    chk("m_grant", {30'd0, grant}, owner);
    chk("m_iload", iload, ramload);
    chk("m_dload", dload, ramload);
    chk("m_starve", {28'd0, dut.starve}, wait_cnt);
  endtask

  task automatic model_edge();
    bit dr;
    bit acc;
    int nxt;
    dr  = dREN || dWEN;
    acc = (ramstate == 2'd2);
    nxt = owner;
    if (owner == 0) begin
      if (dr && !(iREN && wait_cnt == SMAX)) nxt = 2;
      else if (iREN) nxt = 1;
    end else if (owner == 1) begin
      if (!iREN || acc) nxt = 0;
    end else begin
      if (!dr || acc) nxt = 0;
    end
    if (!iREN) wait_cnt = 0;
    else if (owner == 1 && acc) wait_cnt = 0;
    else if (owner == 2 && dr && acc && wait_cnt < SMAX) wait_cnt = wait_cnt + 1;
    owner = nxt;
  endtask

  // One cycle: settle, compare against the model, clock, step past the edge.
  task automatic step();
    #2;
    check_model();
    model_edge();
    @(posedge CLK);
    #1;
  endtask

  typedef struct {
    logic i, d, w;
    logic [1:0] rs;
    logic [31:0] ia, da, ds;
    logic [1:0] g;
    logic iw, dw, rr, rw;
    logic [31:0] ra, rst;
    logic [3:0] sv;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic i, logic d, logic w, logic [1:0] rs,
                              logic [31:0] ia, logic [31:0] da, logic [31:0] ds,
                              logic [1:0] g, logic iw, logic dw, logic rr, logic rw,
                              logic [31:0] ra, logic [31:0] rst, logic [3:0] sv);
    vec_t v;
    v.i = i; v.d = d; v.w = w; v.rs = rs; v.ia = ia; v.da = da; v.ds = ds;
    v.g = g; v.iw = iw; v.dw = dw; v.rr = rr; v.rw = rw; v.ra = ra; v.rst = rst; v.sv = sv;
    return v;
  endfunction

  int got[$];
  int exp_seq[10] = '{2, 2, 2, 2, 1, 2, 2, 2, 2, 1};

  initial begin
    // Fetch completing on its first RAM cycle
    tbl.push_back(mk(1,0,0,0, 32'h40,0,0, 0,1,0,0,0, 0,0,0));
    tbl.push_back(mk(1,0,0,2, 32'h40,0,0, 1,0,0,1,0, 32'h40,0,0));
    tbl.push_back(mk(0,0,0,0, 32'h40,0,0, 0,0,0,0,0, 0,0,0));
    // Simultaneous requests, data first with two BUSY cycles
    tbl.push_back(mk(1,1,0,0, 32'h44,32'h200,0, 0,1,1,0,0, 0,0,0));
    tbl.push_back(mk(1,1,0,1, 32'h44,32'h200,0, 2,1,1,1,0, 32'h200,0,0));
    tbl.push_back(mk(1,1,0,1, 32'h44,32'h200,0, 2,1,1,1,0, 32'h200,0,0));
    tbl.push_back(mk(1,1,0,2, 32'h44,32'h200,0, 2,1,0,1,0, 32'h200,0,0));
    tbl.push_back(mk(1,0,0,0, 32'h44,32'h200,0, 0,1,0,0,0, 0,0,1));
    tbl.push_back(mk(1,0,0,1, 32'h44,32'h200,0, 1,1,0,1,0, 32'h44,0,1));
    tbl.push_back(mk(1,0,0,1, 32'h44,32'h200,0, 1,1,0,1,0, 32'h44,0,1));
    tbl.push_back(mk(1,0,0,2, 32'h44,32'h200,0, 1,0,0,1,0, 32'h44,0,1));
    tbl.push_back(mk(0,0,0,0, 32'h44,32'h200,0, 0,0,0,0,0, 0,0,0));
    // Write wins over read
    tbl.push_back(mk(0,1,1,0, 0,32'h100,32'hDEADBEEF, 0,0,1,0,0, 0,0,0));
    tbl.push_back(mk(0,1,1,1, 0,32'h100,32'hDEADBEEF, 2,0,1,0,1, 32'h100,32'hDEADBEEF,0));
    tbl.push_back(mk(0,1,1,2, 0,32'h100,32'hDEADBEEF, 2,0,0,0,1, 32'h100,32'hDEADBEEF,0));
    tbl.push_back(mk(0,0,0,0, 0,32'h100,32'hDEADBEEF, 0,0,0,0,0, 0,0,0));
    // ERROR re-issues the fetch
    tbl.push_back(mk(1,0,0,0, 32'h80,0,0, 0,1,0,0,0, 0,0,0));
    tbl.push_back(mk(1,0,0,3, 32'h80,0,0, 1,1,0,1,0, 32'h80,0,0));
    tbl.push_back(mk(1,0,0,3, 32'h80,0,0, 1,1,0,1,0, 32'h80,0,0));
    tbl.push_back(mk(1,0,0,3, 32'h80,0,0, 1,1,0,1,0, 32'h80,0,0));
    tbl.push_back(mk(1,0,0,2, 32'h80,0,0, 1,0,0,1,0, 32'h80,0,0));
    tbl.push_back(mk(0,0,0,0, 32'h80,0,0, 0,0,0,0,0, 0,0,0));
    // Abandoned data grant leaves the starve count alone
    tbl.push_back(mk(1,1,0,0, 32'h48,32'h300,0, 0,1,1,0,0, 0,0,0));
    tbl.push_back(mk(1,1,0,2, 32'h48,32'h300,0, 2,1,0,1,0, 32'h300,0,0));
    tbl.push_back(mk(1,1,0,0, 32'h48,32'h300,0, 0,1,1,0,0, 0,0,1));
    tbl.push_back(mk(1,1,0,1, 32'h48,32'h300,0, 2,1,1,1,0, 32'h300,0,1));
    tbl.push_back(mk(1,0,0,1, 32'h48,32'h300,0, 2,1,0,0,0, 32'h300,0,1));
    tbl.push_back(mk(1,0,0,0, 32'h48,32'h300,0, 0,1,0,0,0, 0,0,1));
    tbl.push_back(mk(1,0,0,2, 32'h48,32'h300,0, 1,0,0,1,0, 32'h48,0,1));
    tbl.push_back(mk(0,0,0,0, 32'h48,32'h300,0, 0,0,0,0,0, 0,0,0));

    // Reset with a fetch pending
    nRST = 1'b0; iREN = 1'b1; dREN = 1'b0; dWEN = 1'b0;
    iaddr = 32'h40; daddr = '0; dstore = '0; ramload = 32'h1234_5678; ramstate = 2'd0;
    model_reset();
    #2;
    chk("rst_iwait", {31'd0, iwait}, 32'd1);
    chk("rst_ramREN", {31'd0, ramREN}, 32'd0);
    chk("rst_grant", {30'd0, grant}, 32'd0);
    chk("rst_dwait", {31'd0, dwait}, 32'd0);
    chk("rst_ramaddr", ramaddr, 32'd0);
    @(posedge CLK);
    #1;
    nRST = 1'b1;

    for (int k = 0; k < tbl.size(); k++) begin
      iREN = tbl[k].i; dREN = tbl[k].d; dWEN = tbl[k].w; ramstate = tbl[k].rs;
      iaddr = tbl[k].ia; daddr = tbl[k].da; dstore = tbl[k].ds;
      ramload = 32'hA5A5_0000 + k;
      #1;
      chk($sformatf("t%0d_grant", k), {30'd0, grant}, {30'd0, tbl[k].g});
      chk($sformatf("t%0d_iwait", k), {31'd0, iwait}, {31'd0, tbl[k].iw});
      chk($sformatf("t%0d_dwait", k), {31'd0, dwait}, {31'd0, tbl[k].dw});
      chk($sformatf("t%0d_ramREN", k), {31'd0, ramREN}, {31'd0, tbl[k].rr});
      chk($sformatf("t%0d_ramWEN", k), {31'd0, ramWEN}, {31'd0, tbl[k].rw});
      chk($sformatf("t%0d_ramaddr", k), ramaddr, tbl[k].ra);
      chk($sformatf("t%0d_ramstore", k), ramstore, tbl[k].rst);
      chk($sformatf("t%0d_starve", k), {28'd0, dut.starve}, {28'd0, tbl[k].sv});
      #1;
      model_edge();
      @(posedge CLK);
      #1;
    end

    // Starvation: both sides hold their requests, RAM always answers
    begin
      int sb;
      sb = 0;
      iREN = 1; dREN = 1; dWEN = 0; ramstate = 2'd2;
      iaddr = 32'h500; daddr = 32'h600;
      for (int c = 0; c < 40 && got.size() < 10; c++) begin
        if (grant != 2'd0) begin
          got.push_back(int'(grant));
          if (grant == 2'd1) chk("starve_before_i", sb, 32'd4);
        end
        sb = int'(dut.starve);
        step();
      end
      chk("starve_grants_seen", got.size(), 32'd10);
      for (int k = 0; k < got.size() && k < 10; k++)
        chk($sformatf("starve_seq%0d", k), got[k], exp_seq[k]);
      iREN = 0; dREN = 0;
      step();
      step();
    end

    // Reset in the middle of a data grant
    dREN = 1; iREN = 0; ramstate = 2'd1; daddr = 32'h700;
    step();
    chk("mid_grant_before", {30'd0, grant}, 32'd2);
    nRST = 1'b0;
    #1;
    chk("mid_rst_grant", {30'd0, grant}, 32'd0);
    chk("mid_rst_ramREN", {31'd0, ramREN}, 32'd0);
    chk("mid_rst_dwait", {31'd0, dwait}, 32'd1);
    chk("mid_rst_ramaddr", ramaddr, 32'd0);
    model_reset();
    @(posedge CLK);
    #1;
    nRST = 1'b1;
    dREN = 0;
    step();

    // Random traffic against the model
    for (int c = 0; c < 3000; c++) begin
      iREN     = ($urandom_range(0, 3) != 0);
      dREN     = ($urandom_range(0, 2) == 0);
      dWEN     = ($urandom_range(0, 3) == 0);
      ramstate = 2'($urandom_range(0, 3));
      iaddr    = $urandom;
      daddr    = $urandom;
      dstore   = $urandom;
      ramload  = $urandom;
      step();
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
